// File: rtl/sweep_ctrl.sv
// Frequency sweep sequencer for a sine generator: steps freq_word from f_start
// to f_stop (optionally back down), holding each value for a fixed dwell.
module sweep_ctrl #(
   parameter int FW = 8,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          mode,
   input  logic [FW-1:0] f_start,
   input  logic [FW-1:0] f_stop,
   input  logic [FW-1:0] f_step,
   input  logic [DW-1:0] dwell,
   output logic          gen_en,
   output logic [FW-1:0] freq_word,
   output logic          freq_upd,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN, DONE} state_t;

   state_t        state, state_nxt;
   logic [FW-1:0] fw_nxt;
   logic          upd_nxt;
   logic [DW-1:0] cnt, cnt_nxt;
   logic          load;

   // Sweep parameters captured at start; step and hold are already forced to >= 1.
   logic          mode_q;
   logic [FW-1:0] lo, hi, step;
   logic [DW-1:0] hold;

   logic          dwell_end;
   logic [FW:0]   up_sum, dn_diff;
   logic [FW-1:0] up_val, dn_val;

   assign dwell_end = (cnt == hold - DW'(1));

   // One bit wider than the word so overflow/underflow is visible for clamping.
   assign up_sum  = {1'b0, freq_word} + {1'b0, step};
   assign dn_diff = {1'b0, freq_word} - {1'b0, step};
   assign up_val  = (up_sum >= {1'b0, hi}) ? hi : up_sum[FW-1:0];
   // The first down value is derived from freq_word, which equals hi at that point.
   assign dn_val  = (dn_diff[FW] || (dn_diff[FW-1:0] < lo)) ? lo : dn_diff[FW-1:0];

   // NOTE: every output of this block gets a default first, so no latches are inferred.
   always_comb begin
      state_nxt = state;
      fw_nxt    = freq_word;
      upd_nxt   = 1'b0;
      cnt_nxt   = cnt;
      load      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && !abort) begin
               load      = 1'b1;
               state_nxt = RUN_UP;
               fw_nxt    = f_start;
               upd_nxt   = 1'b1;
               cnt_nxt   = '0;
            end
         end
         RUN_UP: begin
            if (abort) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (!dwell_end) begin
               cnt_nxt = cnt + DW'(1);
            end else if (freq_word >= hi) begin
               cnt_nxt = '0;
               if (mode_q && (lo < hi)) begin
                  state_nxt = RUN_DN;
                  fw_nxt    = dn_val;
                  upd_nxt   = 1'b1;
               end else begin
                  state_nxt = DONE;
               end
            end else begin
               fw_nxt  = up_val;
               upd_nxt = 1'b1;
               cnt_nxt = '0;
            end
         end
         RUN_DN: begin
            if (abort) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (!dwell_end) begin
               cnt_nxt = cnt + DW'(1);
            end else if (freq_word <= lo) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               fw_nxt  = dn_val;
               upd_nxt = 1'b1;
               cnt_nxt = '0;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         freq_word <= '0;
         freq_upd  <= 1'b0;
         cnt       <= '0;
         mode_q    <= 1'b0;
         lo        <= '0;
         hi        <= '0;
         step      <= '0;
         hold      <= '0;
      end else begin
         state     <= state_nxt;
         freq_word <= fw_nxt;
         freq_upd  <= upd_nxt;
         cnt       <= cnt_nxt;
         if (load) begin
            mode_q <= mode;
            lo     <= f_start;
            hi     <= f_stop;
            step   <= (f_step == '0) ? FW'(1) : f_step;
            hold   <= (dwell == '0) ? DW'(1) : dwell;
         end
      end
   end

   assign busy   = (state == RUN_UP) || (state == RUN_DN);
   assign gen_en = busy;
   assign done   = (state == DONE);

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed self-checking bench for sweep_ctrl with hand-computed frequency sequences.
module tb_sweep_ctrl;

   localparam int FW = 8;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, abort, mode;
   logic [FW-1:0] f_start, f_stop, f_step;
   logic [DW-1:0] dwell;
   logic          gen_en, freq_upd, busy, done;
   logic [FW-1:0] freq_word;

   int n_checks = 0;
   int n_fail   = 0;

   sweep_ctrl #(.FW(FW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .mode      (mode),
      .f_start   (f_start),
      .f_stop    (f_stop),
      .f_step    (f_step),
      .dwell     (dwell),
      .gen_en    (gen_en),
      .freq_word (freq_word),
      .freq_upd  (freq_upd),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag, input logic [FW-1:0] fw);
      check({tag, " busy"},   busy,      0);
      check({tag, " gen_en"}, gen_en,    0);
      check({tag, " done"},   done,      0);
      check({tag, " upd"},    freq_upd,  0);
      check({tag, " fw"},     freq_word, fw);
   endtask

   // Runs one sweep and checks every cycle against the listed frequency values.
   task automatic run_sweep(input string tag, input logic m, input logic [FW-1:0] fs,
                            input logic [FW-1:0] fe, input logic [FW-1:0] st,
                            input logic [DW-1:0] dw, input logic [FW-1:0] vals [8],
                            input int n);
      int d;
      int pulses;
      d = (dw == 0) ? 1 : int'(dw);
      pulses = 0;
      mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw;
      start = 1'b1;
      tick();
      // Scramble inputs: the sweep must use the values captured at start.
      start = 1'b0; mode = ~m; f_start = ~fs; f_stop = ~fe; f_step = 8'd77; dwell = 16'd5;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < d; c++) begin
            check({tag, " fw"},   freq_word, vals[i]);
            check({tag, " busy"}, busy,      1);
            check({tag, " gen"},  gen_en,    1);
            check({tag, " done"}, done,      0);
            check({tag, " upd"},  freq_upd,  (c == 0));
            if (freq_upd) pulses++;
            start = (i == 1 && c == 0);
            tick();
         end
      end
      start = 1'b0;
      check({tag, " done pulse"}, done,      1);
      check({tag, " done busy"},  busy,      0);
      check({tag, " done gen"},   gen_en,    0);
      check({tag, " done fw"},    freq_word, vals[n-1]);
      check({tag, " upd count"},  pulses,    n);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_idle({tag, " after done"}, vals[n-1]);
      tick();
      check_idle({tag, " idle"}, vals[n-1]);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
      f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset", 8'd0);
      rst = 1'b0;
      tick(); tick();
      check_idle("post reset", 8'd0);

      run_sweep("up",   1'b0, 8'd10,  8'd40,  8'd10,  16'd3, '{10, 20, 30, 40, 0, 0, 0, 0}, 4);
      run_sweep("tri",  1'b1, 8'd10,  8'd40,  8'd10,  16'd2, '{10, 20, 30, 40, 30, 20, 10, 0}, 7);
      run_sweep("clmp", 1'b1, 8'd200, 8'd255, 8'd100, 16'd1, '{200, 255, 200, 0, 0, 0, 0, 0}, 3);

      // Abort during the second dwell of the up-sweep.
      mode = 1'b0; f_start = 8'd10; f_stop = 8'd40; f_step = 8'd10; dwell = 16'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check("abort pre fw", freq_word, 20);
      check("abort pre busy", busy, 1);
      abort = 1'b1;
      tick();
      check_idle("abort", 8'd20);
      start = 1'b1;
      tick();
      check_idle("abort+start", 8'd20);
      abort = 1'b0; start = 1'b0;
      tick();
      check_idle("abort after", 8'd20);

      // Asynchronous reset in the middle of the down leg of a triangle.
      mode = 1'b1; f_start = 8'd10; f_stop = 8'd40; f_step = 8'd10; dwell = 16'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (8) tick();
      check("rst pre fw", freq_word, 30);
      check("rst pre busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check_idle("async rst", 8'd0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check_idle("rst release", 8'd0);

      run_sweep("degen",  1'b0, 8'd5,  8'd7,  8'd0, 16'd0, '{5, 6, 7, 0, 0, 0, 0, 0}, 3);
      run_sweep("inv",    1'b0, 8'd50, 8'd20, 8'd0, 16'd0, '{50, 0, 0, 0, 0, 0, 0, 0}, 1);
      run_sweep("inv tri", 1'b1, 8'd50, 8'd20, 8'd3, 16'd0, '{50, 0, 0, 0, 0, 0, 0, 0}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL have parameter FW, default 8, frequency-word width; it matches the sine generator freq_word port.
REQ-002 SHALL have parameter DW, default 16, dwell-counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle sweep request, honoured only in IDLE.
REQ-006 SHALL have port abort  input  1  terminates a sweep immediately.
REQ-007 SHALL have port mode  input  1  0 = single up-sweep, 1 = up-then-down triangle.
REQ-008 SHALL have port f_start  input  FW  first frequency word.
REQ-009 SHALL have port f_stop  input  FW  top frequency word.
REQ-010 SHALL have port f_step  input  FW  increment per step.
REQ-011 SHALL have port dwell  input  DW  cycles held per frequency.
REQ-012 SHALL have port gen_en  output  1  enable to sine generator.
REQ-013 SHALL have port freq_word  output  FW  frequency word to sine generator.
REQ-014 SHALL have port freq_upd  output  1  one-cycle pulse when freq_word takes a new value.
REQ-015 SHALL have port busy  output  1  sweep in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 States SHALL be IDLE, RUN_UP, RUN_DN and DONE.
REQ-018 start in IDLE (abort low) at edge T SHALL latch mode, f_start, f_stop, f_step and dwell; later input changes have no effect until the next start.
REQ-019 From T+1: state RUN_UP, freq_word=f_start, gen_en=1, busy=1, freq_upd=1 for one cycle.
REQ-020 Effective dwell D SHALL be max(dwell,1); effective step S SHALL be max(f_step,1).
REQ-021 Each frequency value SHALL be held on freq_word for exactly D cycles, counted by an internal dwell counter.
REQ-022 RUN_UP step rule: next = freq_word+S, computed FW+1 bits wide; if next >= f_stop, freq_word SHALL become f_stop (clamp, no wrap).
REQ-023 A frequency already equal to or above f_stop SHALL be terminal for RUN_UP; this includes f_start >= f_stop, which gives a single dwell at f_start.
REQ-024 After the terminal RUN_UP dwell: mode=0 SHALL go to DONE; mode=1 with f_start<f_stop SHALL go to RUN_DN; otherwise DONE.
REQ-025 RUN_DN SHALL start at freq_word = f_stop-S, clamped to f_start if that is below f_start or underflows; f_stop is not re-dwelt.
REQ-026 In RUN_DN, each step SHALL subtract S, clamped at f_start; the dwell at f_start SHALL be terminal and then go to DONE.
REQ-027 freq_upd SHALL pulse on every freq_word change, including the first value of RUN_DN.
REQ-028 DONE SHALL last one cycle with done=1, gen_en=0 and busy=0, then return to IDLE.
REQ-029 freq_word SHALL retain its last value in DONE and IDLE.
REQ-030 abort in RUN_UP or RUN_DN SHALL go to IDLE at the next edge with gen_en=0, busy=0 and no done pulse.
REQ-031 abort in IDLE or DONE SHALL have no effect, except that abort and start together in IDLE SHALL ignore start.
REQ-032 start while busy SHALL be ignored.
REQ-033 start during the DONE cycle SHALL be ignored.

Reset
REQ-034 rst high SHALL immediately force IDLE, gen_en=0, freq_word=0, freq_upd=0, busy=0, done=0 and dwell counter 0, regardless of clk.
REQ-035 Deassertion of rst SHALL start no sweep without a fresh start pulse.

Verification
REQ-036 Up-sweep: mode=0, f_start=10, f_stop=40, f_step=10, dwell=3 -> freq_word 10,20,30,40 for 3 cycles each; busy 12 cycles; done at cycle 13 after start; 4 freq_upd pulses.
REQ-037 Triangle: mode=1, same values, dwell=2 -> 10,20,30,40,30,20,10 for 2 cycles each; busy 14 cycles; then done.
REQ-038 Clamp and overflow: f_start=200, f_stop=255, f_step=100, dwell=1, mode=1 -> 200,255,200, then done; no wrap to 44.
REQ-039 Degenerate inputs: dwell=0, f_step=0, f_start=5, f_stop=7 -> 5,6,7 for 1 cycle each, then done; a second run with f_start=50, f_stop=20 -> single cycle at 50, then done.
REQ-040 Abort: abort during the second dwell of REQ-036 -> next cycle gen_en=0, busy=0, no done, freq_word holds 20; a start in the same cycle as abort in IDLE is ignored.
REQ-041 Reset mid-sweep: rst asserted between clock edges during RUN_DN -> outputs 0 immediately; after release, outputs stay idle until start.
